// File: rtl/output_deskew_buffer_pkg.sv
// Shared constants and types for the output deskew buffer.
// Optional build macro DESKEW_ROW_TAG_EN adds a per-row tag (see top module).
package output_deskew_buffer_pkg;

    localparam int unsigned ARRAY_W_DEF = 8;
    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned TAG_W       = 8;

    typedef enum logic [1:0] {
        FIFO_IDLE,
        FIFO_PUSH,
        FIFO_POP,
        FIFO_PUSH_POP
    } fifo_op_e;

    // Lane k lags lane 0 by k cycles, so it needs (lanes-1-k) stages to line up.
    function automatic int unsigned lane_delay(input int unsigned lane, input int unsigned lanes);
        return lanes - 1 - lane;
    endfunction

endpackage

// File: rtl/output_deskew_buffer_delay_line.sv
// deskew_delay_line: DLY-stage shift register with synchronous active-high reset.
// DLY == 0 degenerates to a plain wire.
module deskew_delay_line #(
    parameter int unsigned DLY = 1,
    parameter int unsigned W   = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DLY == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q_o = d_i;
        end else begin : g_shift
            logic [W-1:0] stage_q [DLY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < DLY; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < DLY; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/output_deskew_buffer.sv
// Realigns the diagonally skewed array output into whole rows and queues them in a row FIFO.
// Build macro DESKEW_ROW_TAG_EN adds an 8-bit row_tag port carrying a per-row sequence tag.
module output_deskew_buffer
    import output_deskew_buffer_pkg::*;
#(
    parameter int unsigned ARRAY_W = ARRAY_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ARRAY_W-1:0]          in_valid,
    input  logic [ARRAY_W*DATA_W-1:0]   out_act,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [ARRAY_W*DATA_W-1:0]   row_data,
    output logic [$clog2(DEPTH):0]      row_count,
    output logic                        full,
    output logic                        overflow,
    output logic                        skew_err
`ifdef DESKEW_ROW_TAG_EN
    ,
    output logic [TAG_W-1:0]            row_tag
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BUS_W = ARRAY_W * DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ARRAY_W-1:0] dly_valid;
    logic [BUS_W-1:0]   dly_data;

    for (genvar k = 0; k < ARRAY_W; k++) begin : g_lane
        logic [DATA_W:0] lane_q;

        deskew_delay_line #(
            .DLY (lane_delay(k, ARRAY_W)),
            .W   (DATA_W + 1)
        ) u_dly (
            .clk (clk),
            .rst (rst),
            .d_i ({in_valid[k], out_act[k*DATA_W +: DATA_W]}),
            .q_o (lane_q)
        );

        assign dly_valid[k]                 = lane_q[DATA_W];
        assign dly_data[k*DATA_W +: DATA_W] = lane_q[DATA_W-1:0];
    end

    logic aligned_all, aligned_any, lane_skew;
    logic pop, push, drop;
    fifo_op_e op;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d, skew_err_q, skew_err_d;
    logic [BUS_W-1:0] mem_q [DEPTH];

    assign aligned_all = &dly_valid;
    assign aligned_any = |dly_valid;
    assign lane_skew   = aligned_any && !aligned_all;

    assign row_valid = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = row_valid && row_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = aligned_all && (!full || pop);
    assign drop      = aligned_all && full && !pop;

    always_comb begin
        op = FIFO_IDLE;
        if (push && pop) begin
            op = FIFO_PUSH_POP;
        end else if (push) begin
            op = FIFO_PUSH;
        end else if (pop) begin
            op = FIFO_POP;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || drop;
        skew_err_d = skew_err_q || lane_skew;
        unique case (op)
            FIFO_PUSH: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
            FIFO_POP: begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                count_d  = count_q - 1'b1;
            end
            FIFO_PUSH_POP: begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            skew_err_q <= skew_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dly_data;
        end
    end

    // Storage is not reset; gating by row_valid keeps row_data at 0 out of reset.
    assign row_data  = row_valid ? mem_q[rd_ptr_q] : '0;
    assign row_count = count_q;
    assign overflow  = overflow_q;
    assign skew_err  = skew_err_q;

`ifdef DESKEW_ROW_TAG_EN
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] tag_mem_q [DEPTH];

    assign tag_d = push ? tag_q + 1'b1 : tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= tag_q;
        end
    end

    assign row_tag = row_valid ? tag_mem_q[rd_ptr_q] : '0;
`endif

endmodule
